// File: rtl/page_ctrl.sv
// ---------------------------------------------------------------------------
// page_ctrl -- UI page scheduler for the VGA display path.
//
// Holds the current UI page (MAIN / PLAY / PAUSE / OVER), changing it only at
// the frame boundary (x_pos == 0, y_pos == V_ACTIVE). Drives the shared
// background ROM address/bank select from the scan position, composites the
// ROM pixel with the game overlay, applies page effects (pause dimming,
// post-change black fade) and outputs the final 12-bit pixel.
//
// Ports:
//   vga_clk        pixel clock, all state on rising edge
//   vga_rst_n      asynchronous active-low reset
//   x_pos, y_pos   scan position from the VGA timing block
//   video_on       high inside the active area
//   btn_start      start/confirm level (debounced)
//   btn_pause      pause toggle level (debounced)
//   evt_over       game-over level from game logic
//   rom_addr       registered ROM address, x_pos + y_pos*H_ACTIVE
//   rom_sel        registered ROM bank: 0 main, 1 play/pause, 2 over
//   rom_data       ROM read data, valid one cycle after rom_addr
//   overlay_pixel  game renderer pixel, sampled alongside rom_data
//   page           current page (also the FSM state, for observation)
//   frame_start    one-cycle pulse the cycle after the frame boundary
//   pixel_data     final pixel {blue[3:0], green[3:0], red[3:0]}
//
// Timing: there is no handshake; the path is a fixed two-stage pipeline.
// Position in cycle k -> rom_addr/rom_sel after edge k -> rom_data and
// overlay_pixel valid in cycle k+1 -> pixel_data after edge k+1.
// ---------------------------------------------------------------------------
module page_ctrl #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          FADE_FRAMES = 4,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        vga_clk,
    input  logic        vga_rst_n,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        video_on,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        evt_over,
    output logic [18:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic [11:0] rom_data,
    input  logic [11:0] overlay_pixel,
    output logic [1:0]  page,
    output logic        frame_start,
    output logic [11:0] pixel_data
);

    localparam logic [1:0] PG_MAIN  = 2'd0;
    localparam logic [1:0] PG_PLAY  = 2'd1;
    localparam logic [1:0] PG_PAUSE = 2'd2;
    localparam logic [1:0] PG_OVER  = 2'd3;

    localparam logic [7:0] FADE_LOAD = 8'(FADE_FRAMES);

    // Edge-detect registers and sticky pending flags
    logic start_q, pause_q, over_q;
    logic pend_start, pend_pause, pend_over;
    logic edge_start, edge_pause, edge_over;

    // Stage-1 side registers travelling with rom_addr
    logic [1:0] page_s1;
    logic       vo_d1;

    logic [7:0]  fade_cnt;
    logic        frame_bnd;
    logic [1:0]  page_nxt;
    logic [1:0]  sel_nxt;
    logic [18:0] addr_nxt;
    logic [11:0] chosen_pix;
    logic [11:0] comp_pix;

    assign edge_start = btn_start & ~start_q;
    assign edge_pause = btn_pause & ~pause_q;
    assign edge_over  = evt_over  & ~over_q;

    assign frame_bnd = (x_pos == 10'd0) && (y_pos == 10'(V_ACTIVE));

    // Positions outside the active area are still addressed; the delayed
    // video_on masks their output.
    assign addr_nxt = 19'(y_pos) * 19'(H_ACTIVE) + {9'd0, x_pos};

    // Transition decision; only applied when frame_bnd is high.
    // Priority over > pause > start, one transition per boundary.
    always_comb begin
        page_nxt = page;
        case (page)
            PG_MAIN:  if (pend_start) page_nxt = PG_PLAY;
            PG_PLAY: begin
                if (pend_over)       page_nxt = PG_OVER;
                else if (pend_pause) page_nxt = PG_PAUSE;
            end
            PG_PAUSE: if (pend_pause) page_nxt = PG_PLAY;
            PG_OVER:  if (pend_start) page_nxt = PG_MAIN;
            default:  page_nxt = PG_MAIN;
        endcase
    end

    always_comb begin
        sel_nxt = 2'd1;
        if (page == PG_MAIN)      sel_nxt = 2'd0;
        else if (page == PG_OVER) sel_nxt = 2'd2;
    end

    // Stage-2 compositing uses the page that travelled with the address.
    always_comb begin
        chosen_pix = rom_data;
        if (((page_s1 == PG_PLAY) || (page_s1 == PG_PAUSE)) &&
            (overlay_pixel != TRANSPARENT))
            chosen_pix = overlay_pixel;
        comp_pix = chosen_pix;
        if (page_s1 == PG_PAUSE)
            comp_pix = {1'b0, chosen_pix[11:9], 1'b0, chosen_pix[7:5],
                        1'b0, chosen_pix[3:1]};
    end

    // Control: edge detect, pending flags, page FSM, fade counter
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            over_q      <= 1'b0;
            pend_start  <= 1'b0;
            pend_pause  <= 1'b0;
            pend_over   <= 1'b0;
            page        <= PG_MAIN;
            fade_cnt    <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            start_q     <= btn_start;
            pause_q     <= btn_pause;
            over_q      <= evt_over;
            frame_start <= frame_bnd;
            if (frame_bnd) begin
                // Flags from earlier in the frame are consumed or dropped
                // here; an edge in this very cycle survives to the next one.
                pend_start <= edge_start;
                pend_pause <= edge_pause;
                pend_over  <= edge_over;
                page       <= page_nxt;
                if (page_nxt != page)
                    fade_cnt <= FADE_LOAD;
                else if (fade_cnt != 8'd0)
                    fade_cnt <= fade_cnt - 8'd1;
            end else begin
                pend_start <= pend_start | edge_start;
                pend_pause <= pend_pause | edge_pause;
                pend_over  <= pend_over  | edge_over;
            end
        end
    end

    // Pixel pipeline
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            rom_addr   <= 19'd0;
            rom_sel    <= 2'd0;
            page_s1    <= PG_MAIN;
            vo_d1      <= 1'b0;
            pixel_data <= 12'd0;
        end else begin
            rom_addr <= addr_nxt;
            rom_sel  <= sel_nxt;
            page_s1  <= page;
            vo_d1    <= video_on;
            // vo_d1 plus this register gives the two-cycle video_on delay.
            if (vo_d1 && (fade_cnt == 8'd0))
                pixel_data <= comp_pix;
            else
                pixel_data <= 12'd0;
        end
    end

endmodule

// File: tb/tb_page_ctrl.sv
// ---------------------------------------------------------------------------
// tb_page_ctrl -- randomized, scoreboarded bench for page_ctrl.
// The driver applies one scan position per cycle and pushes the predicted
// outputs for the following clock edge into exp_q; the monitor pops one
// entry after every rising edge and compares all outputs.
// ---------------------------------------------------------------------------
module tb_page_ctrl;

    localparam int FADE = 4;
    localparam int P_MAIN = 0, P_PLAY = 1, P_PAUSE = 2, P_OVER = 3;

    logic        vga_clk = 1'b0;
    logic        vga_rst_n = 1'b0;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic        video_on = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_pause = 1'b0;
    logic        evt_over = 1'b0;
    logic [18:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [11:0] rom_data = '0;
    logic [11:0] overlay_pixel = '0;
    logic [1:0]  page;
    logic        frame_start;
    logic [11:0] pixel_data;

    page_ctrl dut (
        .vga_clk       (vga_clk),
        .vga_rst_n     (vga_rst_n),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .video_on      (video_on),
        .btn_start     (btn_start),
        .btn_pause     (btn_pause),
        .evt_over      (evt_over),
        .rom_addr      (rom_addr),
        .rom_sel       (rom_sel),
        .rom_data      (rom_data),
        .overlay_pixel (overlay_pixel),
        .page          (page),
        .frame_start   (frame_start),
        .pixel_data    (pixel_data)
    );

    // ---------------- clock ----------------
    always #5 vga_clk = ~vga_clk;

    // ---------------- scoreboard state ----------------
    // entry: {frame_start, page[1:0], rom_sel[1:0], rom_addr[18:0], pixel[11:0]}
    logic [35:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    int         m_page, m_page_prev, m_fade;
    logic       m_vo_prev;
    logic [2:0] m_pend;  // bit0 start, bit1 pause, bit2 over
    logic [2:0] m_lv;    // previous button levels

    function automatic void model_reset();
        m_page = P_MAIN; m_page_prev = P_MAIN; m_fade = 0;
        m_vo_prev = 1'b0; m_pend = '0; m_lv = '0;
    endfunction

    function automatic int half_channels(int c);
        int r, g, b;
        r = (c % 16) / 2;
        g = ((c / 16) % 16) / 2;
        b = ((c / 256) % 16) / 2;
        return b * 256 + g * 16 + r;
    endfunction

    function automatic int composite(int pg, int rom, int ov);
        int c;
        if (pg == P_MAIN || pg == P_OVER) return rom;
        c = (ov == 'hF0F) ? rom : ov;
        if (pg == P_PAUSE) c = half_channels(c);
        return c;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input int x, input int y, input logic vo,
                         input logic [2:0] lv, input int rom, input int ov);
        int   addr, sel, pix, nxt;
        logic bnd;
        logic [2:0] edges;
        logic [35:0] e;
        @(negedge vga_clk);
        x_pos = 10'(x); y_pos = 10'(y); video_on = vo;
        btn_start = lv[0]; btn_pause = lv[1]; evt_over = lv[2];
        rom_data = 12'(rom); overlay_pixel = 12'(ov);

        bnd   = (x == 0) && (y == 480);
        edges = lv & ~m_lv;
        addr  = (y * 640 + x) % 524288;
        sel   = (m_page == P_MAIN) ? 0 : (m_page == P_OVER) ? 2 : 1;
        pix   = (m_vo_prev && m_fade == 0) ? composite(m_page_prev, rom, ov) : 0;
        nxt   = m_page;
        if (bnd) begin
            if (m_page == P_MAIN && m_pend[0])       nxt = P_PLAY;
            else if (m_page == P_PLAY && m_pend[2])  nxt = P_OVER;
            else if (m_page == P_PLAY && m_pend[1])  nxt = P_PAUSE;
            else if (m_page == P_PAUSE && m_pend[1]) nxt = P_PLAY;
            else if (m_page == P_OVER && m_pend[0])  nxt = P_MAIN;
            if (nxt != m_page) m_fade = FADE;
            else if (m_fade > 0) m_fade = m_fade - 1;
            m_pend = edges;
        end else begin
            m_pend = m_pend | edges;
        end
        m_page_prev = m_page;
        m_page      = nxt;
        m_vo_prev   = vo;
        m_lv        = lv;
        e = {bnd, 2'(nxt), 2'(sel), 19'(addr), 12'(pix)};
        exp_q.push_back(e);
    endtask

    function automatic int rnd_rom();
        return ($urandom_range(0, 3) == 0) ? 'h888 : int'($urandom_range(0, 4095));
    endfunction

    function automatic int rnd_ov();
        int r;
        r = $urandom_range(0, 3);
        if (r < 2) return 'hF0F;
        if (r == 2) return 'h0F0;
        return $urandom_range(0, 4095);
    endfunction

    // One compressed frame: n random scan positions (never the boundary),
    // the boundary cycle, then three blanking cycles. 'pulse' buttons get a
    // short high pulse mid-frame; 'bnd_rise' buttons rise in the boundary cycle.
    task automatic run_frame(input int n, input logic [2:0] pulse, input logic [2:0] bnd_rise);
        int ps[3], pl[3];
        int x, y;
        logic [2:0] lv;
        for (int j = 0; j < 3; j++) begin
            ps[j] = $urandom_range(1, n - 6);
            pl[j] = $urandom_range(1, 3);
        end
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 799);
            y = ($urandom_range(0, 7) == 0) ? $urandom_range(481, 524) : $urandom_range(0, 479);
            for (int j = 0; j < 3; j++)
                lv[j] = pulse[j] && (i >= ps[j]) && (i < ps[j] + pl[j]);
            drive(x, y, (x < 640) && (y < 480), lv, rnd_rom(), rnd_ov());
        end
        drive(0, 480, 1'b0, bnd_rise, rnd_rom(), rnd_ov());
        drive($urandom_range(1, 799), 481, 1'b0, bnd_rise, rnd_rom(), rnd_ov());
        drive($urandom_range(1, 799), 481, 1'b0, bnd_rise, rnd_rom(), rnd_ov());
        drive($urandom_range(1, 799), 482, 1'b0, 3'b000, rnd_rom(), rnd_ov());
    endtask

    // Asserts reset between edges and checks the outputs clear immediately.
    task automatic do_reset();
        @(negedge vga_clk);
        vga_rst_n = 1'b0;
        btn_start = 1'b0; btn_pause = 1'b0; evt_over = 1'b0;
        #1;
        chk("rst_page", 32'(page), 32'd0);
        chk("rst_rom_sel", 32'(rom_sel), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pixel", 32'(pixel_data), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #2;
        vga_rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [35:0] e;
        forever begin
            @(posedge vga_clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame_start", 32'(frame_start), 32'(e[35]));
                chk("page", 32'(page), 32'(e[34:33]));
                chk("rom_sel", 32'(rom_sel), 32'(e[32:31]));
                chk("rom_addr", 32'(rom_addr), 32'(e[30:12]));
                chk("pixel_data", 32'(pixel_data), 32'(e[11:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        // MAIN: address sweep including (5,2) -> 1285
        drive(5, 2, 1'b1, 3'b000, 'h123, 'h0F0);
        drive(6, 2, 1'b1, 3'b000, 'h888, 'hF0F);
        run_frame(40, 3'b000, 3'b000);
        // MAIN -> PLAY, then fade frames and visible play content
        run_frame(40, 3'b001, 3'b000);
        repeat (5) run_frame(40, 3'b000, 3'b000);
        // PLAY: pause and over in the same frame -> OVER
        run_frame(40, 3'b110, 3'b000);
        // start edge in the boundary cycle is held for the following boundary
        run_frame(40, 3'b000, 3'b001);
        run_frame(40, 3'b000, 3'b000);
        // MAIN -> PLAY -> PAUSE with dimmed content
        run_frame(40, 3'b001, 3'b000);
        repeat (5) run_frame(40, 3'b000, 3'b000);
        run_frame(40, 3'b010, 3'b000);
        repeat (5) run_frame(40, 3'b000, 3'b000);
        // PAUSE: start+pause -> PLAY; pause -> PAUSE; lone start/over ignored
        run_frame(40, 3'b011, 3'b000);
        run_frame(40, 3'b010, 3'b000);
        run_frame(40, 3'b001, 3'b000);
        run_frame(40, 3'b100, 3'b000);
        run_frame(40, 3'b010, 3'b000);
        // PLAY -> OVER, then reset partway through a fading frame
        run_frame(40, 3'b100, 3'b000);
        for (int i = 0; i < 10; i++)
            drive(i * 7, 100, 1'b1, 3'b000, rnd_rom(), rnd_ov());
        do_reset();
        drive(5, 2, 1'b1, 3'b000, 'h456, 'h0F0);
        run_frame(40, 3'b000, 3'b000);
        run_frame(40, 3'b001, 3'b000);

        // Random sessions
        for (int f = 0; f < 30; f++)
            run_frame($urandom_range(20, 50), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);

        @(posedge vga_clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
